// File: rtl/instr_register_pkg.sv
// Shared types and constants for instr_register and its read-side executor.
// The state enum for instr_exec_reader lives here so the module declares no local typedefs.
package instr_register_pkg;

    localparam int unsigned DEPTH       = 32;
    localparam int unsigned ADDR_W      = $clog2(DEPTH);
    localparam int unsigned EXEC_RD_LAT = 1;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0]       operand_t;
    typedef logic [ADDR_W-1:0]        address_t;
    typedef logic signed [63:0]       result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        EX_IDLE  = 2'd0,
        EX_FETCH = 2'd1,
        EX_EXEC  = 2'd2,
        EX_OUT   = 2'd3
    } exec_state_t;

    function automatic result_t sext_operand(input operand_t op);
        return result_t'(op);
    endfunction

endpackage

// File: rtl/instr_alu.sv
// Purely combinational instruction executor: 64-bit signed result plus a divide-by-zero flag.
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output result_t      result,
    output logic         divz
);

    result_t a_s;
    result_t b_s;

    // Operands are widened first so MULT yields the full product and DIV/MOD use 64-bit signed math.
    always_comb begin
        a_s    = sext_operand(instr.op_a);
        b_s    = sext_operand(instr.op_b);
        result = 64'sd0;
        divz   = 1'b0;
        case (instr.opc)
            ZERO:  result = 64'sd0;
            PASSA: result = a_s;
            PASSB: result = b_s;
            ADD:   result = a_s + b_s;
            SUB:   result = a_s - b_s;
            MULT:  result = a_s * b_s;
            DIV: begin
                if (b_s == 64'sd0) begin
                    divz = 1'b1;
                end else begin
                    result = a_s / b_s;
                end
            end
            MOD: begin
                if (b_s == 64'sd0) begin
                    divz = 1'b1;
                end else begin
                    result = a_s % b_s;
                end
            end
            default: result = 64'sd0;
        endcase
    end

endmodule

// File: rtl/instr_exec_reader.sv
// Read-side master for instr_register: fetches a window of entries, executes them, streams results.
// Optional macro INSTR_EXEC_DIVZ_EN adds res_divz and sticky divz_seen outputs.
module instr_exec_reader
    import instr_register_pkg::*;
#(
    parameter int unsigned RD_LAT = EXEC_RD_LAT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     start_ptr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         res_valid,
    input  logic         res_ready,
    output result_t      result,
    output address_t     res_ptr,
    output logic         busy,
    output logic         done
`ifdef INSTR_EXEC_DIVZ_EN
    ,
    output logic         res_divz,
    output logic         divz_seen
`endif
);

    localparam int unsigned      LAT_W    = 4;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
    localparam address_t         PTR_LAST = address_t'(DEPTH - 1);

    exec_state_t      state_q, state_d;
    address_t         read_pointer_q, read_pointer_d;
    address_t         res_ptr_q, res_ptr_d;
    logic [5:0]       remaining_q, remaining_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    instruction_t     instr_q, instr_d;
    result_t          result_q, result_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    result_t          alu_result;
    logic             alu_divz;
`ifdef INSTR_EXEC_DIVZ_EN
    logic             res_divz_q, res_divz_d;
    logic             divz_seen_q, divz_seen_d;
`endif

    instr_alu u_alu (
        .instr  (instr_q),
        .result (alu_result),
        .divz   (alu_divz)
    );

    // Next-state logic for the fetch/execute/output sequencer and its datapath registers.
    always_comb begin
        state_d        = state_q;
        read_pointer_d = read_pointer_q;
        remaining_d    = remaining_q;
        lat_d          = lat_q;
        instr_d        = instr_q;
        result_d       = result_q;
        res_ptr_d      = res_ptr_q;
        res_valid_d    = res_valid_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
`ifdef INSTR_EXEC_DIVZ_EN
        res_divz_d     = res_divz_q;
        divz_seen_d    = divz_seen_q;
`endif
        case (state_q)
            EX_IDLE: begin
                if (start) begin
`ifdef INSTR_EXEC_DIVZ_EN
                    divz_seen_d = 1'b0;
`endif
                    if (count != 6'd0) begin
                        read_pointer_d = start_ptr;
                        remaining_d    = count;
                        lat_d          = '0;
                        busy_d         = 1'b1;
                        state_d        = EX_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            EX_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    instr_d = instruction_word;
                    lat_d   = '0;
                    state_d = EX_EXEC;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            EX_EXEC: begin
                // Divide-by-zero is forced to zero here as well, independent of the ALU's own default.
                result_d    = alu_divz ? 64'sd0 : alu_result;
                res_ptr_d   = read_pointer_q;
                res_valid_d = 1'b1;
                state_d     = EX_OUT;
`ifdef INSTR_EXEC_DIVZ_EN
                res_divz_d  = alu_divz;
                divz_seen_d = divz_seen_q | alu_divz;
`endif
            end
            EX_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    remaining_d = remaining_q - 6'd1;
                    if (remaining_q != 6'd1) begin
                        read_pointer_d = (read_pointer_q == PTR_LAST) ? 5'd0 : read_pointer_q + 5'd1;
                        state_d        = EX_FETCH;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = EX_IDLE;
                    end
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = EX_IDLE;
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset abandons any run and drops a pending result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= EX_IDLE;
            read_pointer_q <= 5'd0;
            res_ptr_q      <= 5'd0;
            remaining_q    <= 6'd0;
            lat_q          <= '0;
            instr_q        <= '0;
            result_q       <= 64'sd0;
            res_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef INSTR_EXEC_DIVZ_EN
            res_divz_q     <= 1'b0;
            divz_seen_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            read_pointer_q <= read_pointer_d;
            res_ptr_q      <= res_ptr_d;
            remaining_q    <= remaining_d;
            lat_q          <= lat_d;
            instr_q        <= instr_d;
            result_q       <= result_d;
            res_valid_q    <= res_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef INSTR_EXEC_DIVZ_EN
            res_divz_q     <= res_divz_d;
            divz_seen_q    <= divz_seen_d;
`endif
        end
    end

    assign read_pointer = read_pointer_q;
    assign res_valid    = res_valid_q;
    assign result       = result_q;
    assign res_ptr      = res_ptr_q;
    assign busy         = busy_q;
    assign done         = done_q;
`ifdef INSTR_EXEC_DIVZ_EN
    assign res_divz     = res_divz_q;
    assign divz_seen    = divz_seen_q;
`endif

endmodule

// File: tb/tb_instr_exec_reader.sv
// Self-checking bench for instr_exec_reader: directed scenarios plus randomized windows
// checked against a behavioural model of the instruction set and window walk.
module tb_instr_exec_reader;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     start_ptr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready;
    result_t      result;
    address_t     res_ptr;
    logic         busy;
    logic         done;
`ifdef INSTR_EXEC_DIVZ_EN
    logic         res_divz;
    logic         divz_seen;
`endif

    instruction_t mem [DEPTH];
    int checks   = 0;
    int failures = 0;

    // Observations gathered by run_window, judged by the calling test task.
    longint   obs_res[$];
    address_t obs_ptr[$];
    address_t rp_trace[$];
`ifdef INSTR_EXEC_DIVZ_EN
    logic     obs_divz[$];
`endif
    int done_cnt, done_cyc, busy_at_done, stall_viol, timed_out, busy_after_start, valid_seen;

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_exec_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_ptr        (start_ptr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .result           (result),
        .res_ptr          (res_ptr),
        .busy             (busy),
        .done             (done)
`ifdef INSTR_EXEC_DIVZ_EN
        ,
        .res_divz         (res_divz),
        .divz_seen        (divz_seen)
`endif
    );

    function automatic longint ref_exec(input instruction_t ins);
        longint a;
        longint b;
        a = longint'(int'(ins.op_a));
        b = longint'(int'(ins.op_b));
        case (ins.opc)
            PASSA:   return a;
            PASSB:   return b;
            ADD:     return a + b;
            SUB:     return a - b;
            MULT:    return a * b;
            DIV:     return (b == 0) ? 64'sd0 : a / b;
            MOD:     return (b == 0) ? 64'sd0 : a % b;
            default: return 64'sd0;
        endcase
    endfunction

    function automatic instruction_t mk(input int opc, input int a, input int b);
        instruction_t ins;
        ins.opc  = opcode_t'(4'(opc));
        ins.op_a = operand_t'(a);
        ins.op_b = operand_t'(b);
        return ins;
    endfunction

    function automatic int rand_operand();
        case ($urandom_range(3))
            0:       return $urandom_range(16) - 8;
            1:       return ($urandom_range(1) == 1) ? 32'h7FFFFFFF : 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_window(input address_t sp, input logic [5:0] cnt, input int ready_pct,
                              input int stall_n, input int inject_at, input int max_cyc);
        int       cyc;
        int       stall_left;
        logic     pend;
        result_t  pend_res;
        address_t pend_ptr;
        address_t pend_rp;
        obs_res.delete(); obs_ptr.delete(); rp_trace.delete();
`ifdef INSTR_EXEC_DIVZ_EN
        obs_divz.delete();
`endif
        done_cnt = 0; done_cyc = -1; busy_at_done = 0; stall_viol = 0;
        timed_out = 0; busy_after_start = 0; valid_seen = 0;
        stall_left = stall_n; pend = 1'b0; cyc = 0;
        pend_res = '0; pend_ptr = '0; pend_rp = '0;
        @(negedge clk);
        start_ptr = sp; count = cnt; start = 1'b1; res_ready = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = (cyc == inject_at);
            if (start) begin
                start_ptr = sp + 5'd7;
                count     = 6'd1;
            end
            if (cyc == 1) busy_after_start = busy;
            if (busy && (rp_trace.size() == 0 || rp_trace[$] != read_pointer))
                rp_trace.push_back(read_pointer);
            if (pend && (!res_valid || result !== pend_res || res_ptr !== pend_ptr || read_pointer !== pend_rp))
                stall_viol++;
            if (stall_n > 0) res_ready = (stall_left == 0);
            else             res_ready = ($urandom_range(99) < ready_pct);
            if (res_valid) valid_seen = 1;
            if (res_valid && res_ready) begin
                obs_res.push_back(result);
                obs_ptr.push_back(res_ptr);
`ifdef INSTR_EXEC_DIVZ_EN
                obs_divz.push_back(res_divz);
`endif
                stall_left = stall_n;
            end
            if (res_valid && !res_ready && stall_left > 0) stall_left--;
            pend = res_valid && !res_ready;
            pend_res = result; pend_ptr = res_ptr; pend_rp = read_pointer;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (busy) busy_at_done++;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (cyc >= max_cyc) begin
                timed_out = 1;
                break;
            end
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; start_ptr = '0; count = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({read_pointer, res_ptr, res_valid, busy, done} !== 13'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got rp=%0d rptr=%0d valid=%b busy=%b done=%b, expected all 0",
                     read_pointer, res_ptr, res_valid, busy, done);
        end
        checks++;
        if (result !== 64'sd0) begin
            failures++;
            $display("FAIL reset_result: got %0d expected 0", result);
        end
`ifdef INSTR_EXEC_DIVZ_EN
        checks++;
        if ({res_divz, divz_seen} !== 2'b00) begin
            failures++;
            $display("FAIL reset_divz: got %b%b expected 00", res_divz, divz_seen);
        end
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        longint exp_r[3] = '{64'sd8, -64'sd3, -64'sd42};
        mem[0] = mk(ADD, 5, 3);
        mem[1] = mk(SUB, 5, 8);
        mem[2] = mk(MULT, -7, 6);
        run_window(5'd0, 6'd3, 100, 0, 0, 200);
        checks++;
        if (timed_out != 0 || obs_res.size() != 3) begin
            failures++;
            $display("FAIL basic_count: got %0d results timeout=%0d, expected 3", obs_res.size(), timed_out);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_res[i] !== exp_r[i] || obs_ptr[i] !== address_t'(i)) begin
                    failures++;
                    $display("FAIL basic_res%0d: got %0d@%0d expected %0d@%0d", i, obs_res[i], obs_ptr[i], exp_r[i], i);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 3 * (EXEC_RD_LAT + 2) + 1) begin
            failures++;
            $display("FAIL basic_done: got %0d pulses at cycle %0d expected 1 at %0d", done_cnt, done_cyc, 3 * (EXEC_RD_LAT + 2) + 1);
        end
        checks++;
        if (busy_after_start != 1 || busy_at_done != 0) begin
            failures++;
            $display("FAIL basic_busy: got busy_after_start=%0d busy_at_done=%0d expected 1/0", busy_after_start, busy_at_done);
        end
    endtask

    task automatic test_divmod();
        mem[5] = mk(DIV, 7, 0);
        mem[6] = mk(MOD, -7, 2);
        run_window(5'd5, 6'd2, 100, 0, 0, 200);
        checks++;
        if (obs_res.size() != 2) begin
            failures++;
            $display("FAIL divmod_count: got %0d expected 2", obs_res.size());
        end else begin
            checks++;
            if (obs_res[0] !== 64'sd0 || obs_res[1] !== -64'sd1) begin
                failures++;
                $display("FAIL divmod_res: got %0d,%0d expected 0,-1", obs_res[0], obs_res[1]);
            end
`ifdef INSTR_EXEC_DIVZ_EN
            checks++;
            if (obs_divz[0] !== 1'b1 || obs_divz[1] !== 1'b0 || divz_seen !== 1'b1) begin
                failures++;
                $display("FAIL divmod_divz: got %b,%b seen=%b expected 1,0 seen=1", obs_divz[0], obs_divz[1], divz_seen);
            end
`endif
        end
    endtask

    task automatic test_wrap();
        address_t exp_p[4];
        exp_p[0] = 5'd30; exp_p[1] = 5'd31; exp_p[2] = 5'd0; exp_p[3] = 5'd1;
        for (int i = 0; i < 4; i++) mem[exp_p[i]] = mk(ADD, 100 * i, int'(exp_p[i]));
        run_window(5'd30, 6'd4, 100, 0, 0, 200);
        checks++;
        if (rp_trace.size() != 4 || obs_res.size() != 4) begin
            failures++;
            $display("FAIL wrap_count: got %0d pointers %0d results expected 4/4", rp_trace.size(), obs_res.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rp_trace[i] !== exp_p[i] || obs_ptr[i] !== exp_p[i] || obs_res[i] !== ref_exec(mem[exp_p[i]])) begin
                    failures++;
                    $display("FAIL wrap_%0d: got rp=%0d rptr=%0d res=%0d expected %0d/%0d/%0d", i, rp_trace[i],
                             obs_ptr[i], obs_res[i], exp_p[i], exp_p[i], ref_exec(mem[exp_p[i]]));
                end
            end
        end
`ifdef INSTR_EXEC_DIVZ_EN
        checks++;
        if (divz_seen !== 1'b0) begin
            failures++;
            $display("FAIL wrap_divz_seen: got %b expected 0 after new start", divz_seen);
        end
`endif
    endtask

    task automatic test_backpressure();
        for (int i = 10; i < 13; i++) mem[i] = mk($urandom_range(7), rand_operand(), rand_operand());
        mem[17] = mk(ADD, 1, 1);
        run_window(5'd10, 6'd3, 100, 5, 4, 400);
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_viol);
        end
        checks++;
        if (obs_res.size() != 3 || done_cnt != 1 || done_cyc != 3 * (EXEC_RD_LAT + 2) + 1 + 3 * 5) begin
            failures++;
            $display("FAIL bp_run: got %0d results %0d done at %0d expected 3/1 at %0d", obs_res.size(), done_cnt,
                     done_cyc, 3 * (EXEC_RD_LAT + 2) + 1 + 3 * 5);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_res[i] !== ref_exec(mem[10 + i]) || obs_ptr[i] !== address_t'(10 + i)) begin
                    failures++;
                    $display("FAIL bp_res%0d: got %0d@%0d expected %0d@%0d", i, obs_res[i], obs_ptr[i],
                             ref_exec(mem[10 + i]), 10 + i);
                end
            end
        end
    endtask

    task automatic test_mult_count0();
        mem[15] = mk(MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);
        run_window(5'd15, 6'd1, 100, 0, 0, 100);
        checks++;
        if (obs_res.size() != 1 || obs_res[0] !== 64'sh3FFFFFFF00000001) begin
            failures++;
            $display("FAIL mult_max: got %0d results first=%h expected 3fffffff00000001", obs_res.size(),
                     (obs_res.size() > 0) ? obs_res[0] : 64'sd0);
        end
        run_window(5'd3, 6'd0, 100, 0, 0, 50);
        checks++;
        if (done_cnt != 1 || done_cyc != 1 || valid_seen != 0 || busy_after_start != 0) begin
            failures++;
            $display("FAIL count0: got done=%0d@%0d valid_seen=%0d busy=%0d expected 1@1/0/0", done_cnt, done_cyc,
                     valid_seen, busy_after_start);
        end
    endtask

    task automatic test_reset_mid_out();
        int waited = 0;
        int done_during = 0;
        mem[8] = mk(ADD, 11, 22);
        @(negedge clk);
        start_ptr = 5'd8; count = 6'd2; start = 1'b1; res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!res_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!res_valid) begin
            failures++;
            $display("FAIL rstmid_reach: got res_valid=0 expected 1 within 20 cycles");
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({read_pointer, res_ptr, res_valid, busy, done} !== 13'd0 || result !== 64'sd0) begin
            failures++;
            $display("FAIL rstmid_out: got rp=%0d rptr=%0d valid=%b busy=%b done=%b res=%0d expected all 0",
                     read_pointer, res_ptr, res_valid, busy, done, result);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) done_during++;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || res_valid || busy) done_during++;
        end
        checks++;
        if (done_during != 0) begin
            failures++;
            $display("FAIL rstmid_quiet: got %0d cycles with done/valid/busy expected 0", done_during);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            address_t   sp;
            logic [5:0] cnt;
            int         pct;
            int         op;
            for (int i = 0; i < DEPTH; i++) begin
                op = $urandom_range(9);
                if (op > 7) op = 8 + $urandom_range(7);
                mem[i] = mk(op, rand_operand(), rand_operand());
            end
            sp  = address_t'($urandom_range(DEPTH - 1));
            cnt = 6'($urandom_range(DEPTH));
            pct = 40 + $urandom_range(60);
            run_window(sp, cnt, pct, 0, 0, int'(cnt) * 60 + 40);
            checks++;
            if (timed_out != 0 || obs_res.size() != int'(cnt) || done_cnt != 1 || stall_viol != 0) begin
                failures++;
                $display("FAIL rand%0d_run: got %0d results done=%0d timeout=%0d stall=%0d expected %0d/1/0/0",
                         it, obs_res.size(), done_cnt, timed_out, stall_viol, cnt);
            end else begin
                for (int k = 0; k < int'(cnt); k++) begin
                    address_t p;
                    p = address_t'((int'(sp) + k) % DEPTH);
                    checks++;
                    if (obs_res[k] !== ref_exec(mem[p]) || obs_ptr[k] !== p) begin
                        failures++;
                        $display("FAIL rand%0d_res%0d: got %0d@%0d expected %0d@%0d", it, k, obs_res[k],
                                 obs_ptr[k], ref_exec(mem[p]), p);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = mk(ZERO, 0, 0);
        test_reset();
        test_basic();
        test_divmod();
        test_wrap();
        test_backpressure();
        test_mult_count0();
        test_reset_mid_out();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
